// File: rtl/digit_pkg.sv
// digit_pkg: shared constants, FSM state type and ambiguity helper for the digit detector
package digit_pkg;
    localparam int NUM_CLASSES = 10;
    localparam int BASE_ADDR   = 8;
    localparam int ADDR_W      = 5;
    localparam int DATA_W      = 4;
    localparam int MARGIN      = 1;
    localparam int CNT_W       = 4;

    typedef enum logic [2:0] {IDLE, SCAN, DRAIN, FINISH, HOLD} detState_t;

    // Gap is computed one bit wider so the unsigned difference never wraps
    function automatic logic is_ambiguous(input logic [DATA_W-1:0] best, input logic [DATA_W-1:0] second);
        logic [DATA_W:0] gap;
        gap = {1'b0, best} - {1'b0, second};
        return gap < (DATA_W+1)'(MARGIN);
    endfunction
endpackage

// File: rtl/digit_detector_if.sv
// digit_detector_if: sigmoid read port, trigger and result handshake of the digit detector
interface digit_detector_if;
    import digit_pkg::*;
    logic              network_done;
    logic              sig_rd_en;
    logic [ADDR_W-1:0] sig_rd_addr;
    logic [DATA_W-1:0] sig_rd_data;
    logic              busy;
    logic [3:0]        digit;
    logic [DATA_W-1:0] max_value;
    logic              ambiguous;
    logic              digit_valid;
    logic              result_ack;
    logic              overrun;

    modport master (
        input  network_done, sig_rd_data, result_ack,
        output sig_rd_en, sig_rd_addr, busy, digit, max_value, ambiguous, digit_valid, overrun
    );
    modport slave (
        output network_done, sig_rd_data, result_ack,
        input  sig_rd_en, sig_rd_addr, busy, digit, max_value, ambiguous, digit_valid, overrun
    );
endinterface

// File: rtl/flex_counter.sv
// flex_counter: clearable up-counter that wraps to 0 after reaching rollover_val
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);
    assign rollover_flag = count_out == rollover_val;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            count_out <= '0;
        else if (clear)
            count_out <= '0;
        else if (count_enable)
            count_out <= rollover_flag ? '0 : count_out + 1'b1;
    end
endmodule

// File: rtl/digit_detector.sv
// digit_detector: argmax over the layer-2 sigmoid outputs, result held under valid/ack
module digit_detector
    import digit_pkg::*;
(
    input  logic clk,
    input  logic n_rst,
    digit_detector_if.master bus
);
    detState_t         state;
    logic [CNT_W-1:0]  idx;
    logic [CNT_W-1:0]  j_d;
    logic [CNT_W-1:0]  best_idx;
    logic              last;
    logic              data_vld;
    logic              start;
    logic [DATA_W-1:0] best;
    logic [DATA_W-1:0] second;

    flex_counter #(.NUM_CNT_BITS(CNT_W)) u_idx (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (state != SCAN),
        .count_enable (state == SCAN),
        .rollover_val (CNT_W'(NUM_CLASSES - 1)),
        .count_out    (idx),
        .rollover_flag(last)
    );

    assign start = bus.network_done && (state == IDLE || state == HOLD);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state           <= IDLE;
            data_vld        <= 1'b0;
            j_d             <= '0;
            best            <= '0;
            second          <= '0;
            best_idx        <= '0;
            bus.sig_rd_en   <= 1'b0;
            bus.sig_rd_addr <= '0;
            bus.busy        <= 1'b0;
            bus.digit       <= '0;
            bus.max_value   <= '0;
            bus.ambiguous   <= 1'b0;
            bus.digit_valid <= 1'b0;
            bus.overrun     <= 1'b0;
        end else begin
            data_vld <= bus.sig_rd_en;
            j_d      <= idx;
            if (bus.network_done && state != IDLE)
                bus.overrun <= 1'b1;
            // Strict compares: on a tie the earlier class keeps the lead
            if (data_vld) begin
                if (bus.sig_rd_data > best) begin
                    second   <= best;
                    best     <= bus.sig_rd_data;
                    best_idx <= j_d;
                end else if (bus.sig_rd_data > second)
                    second <= bus.sig_rd_data;
            end
            if (start) begin
                state           <= SCAN;
                best            <= '0;
                second          <= '0;
                best_idx        <= '0;
                bus.sig_rd_en   <= 1'b1;
                bus.sig_rd_addr <= ADDR_W'(BASE_ADDR);
                bus.busy        <= 1'b1;
                bus.digit_valid <= 1'b0;
            end else begin
                case (state)
                    SCAN: begin
                        state           <= last ? DRAIN : SCAN;
                        bus.sig_rd_en   <= !last;
                        bus.sig_rd_addr <= last ? '0 : ADDR_W'(BASE_ADDR + int'(idx) + 1);
                    end
                    DRAIN: state <= FINISH;
                    FINISH: begin
                        state           <= HOLD;
                        bus.digit       <= best_idx;
                        bus.max_value   <= best;
                        bus.ambiguous   <= is_ambiguous(best, second);
                        bus.digit_valid <= 1'b1;
                        bus.busy        <= 1'b0;
                    end
                    HOLD: if (bus.result_ack) begin
                        state           <= IDLE;
                        bus.digit_valid <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_digit_detector.sv
// tb_digit_detector: directed checks of argmax, latency, handshake, overrun and async reset
module tb_digit_detector;
    import digit_pkg::*;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    int checks = 0;
    int failures = 0;
    logic [DATA_W-1:0] mem [0:31];

    digit_detector_if bus();
    digit_detector dut (.clk(clk), .n_rst(n_rst), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk)
        if (bus.sig_rd_en) bus.sig_rd_data <= mem[bus.sig_rd_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [39:0] p);
        for (int i = 0; i < 32; i++) mem[i] = '0;
        for (int i = 0; i < NUM_CLASSES; i++) mem[BASE_ADDR + i] = p[4*i +: 4];
    endtask

    task automatic pulse_done();
        bus.network_done = 1'b1;
        @(negedge clk);
        bus.network_done = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rd_en"}, 32'(bus.sig_rd_en), 0);
        chk({tag, "_addr"}, 32'(bus.sig_rd_addr), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_digit"}, 32'(bus.digit), 0);
        chk({tag, "_max"}, 32'(bus.max_value), 0);
        chk({tag, "_amb"}, 32'(bus.ambiguous), 0);
        chk({tag, "_valid"}, 32'(bus.digit_valid), 0);
        chk({tag, "_overrun"}, 32'(bus.overrun), 0);
    endtask

    task automatic run_scan(input string tag, input int e_digit, input int e_max, input int e_amb);
        int rd_cnt = 0;
        int bad_addr = 0;
        int busy_cnt = 0;
        int early = 0;
        pulse_done();
        for (int k = 0; k < 12; k++) begin
            if (bus.sig_rd_en) begin
                if (bus.sig_rd_addr !== 5'(BASE_ADDR + rd_cnt)) bad_addr++;
                rd_cnt++;
            end else if (bus.sig_rd_addr !== '0) bad_addr++;
            if (bus.busy) busy_cnt++;
            if (bus.digit_valid !== 1'b0) early++;
            @(negedge clk);
        end
        chk({tag, "_rd_cycles"}, rd_cnt, NUM_CLASSES);
        chk({tag, "_addr_seq"}, bad_addr, 0);
        chk({tag, "_busy_cycles"}, busy_cnt, 12);
        chk({tag, "_early_valid"}, early, 0);
        chk({tag, "_valid_e12"}, 32'(bus.digit_valid), 1);
        chk({tag, "_digit"}, 32'(bus.digit), e_digit);
        chk({tag, "_max"}, 32'(bus.max_value), e_max);
        chk({tag, "_amb"}, 32'(bus.ambiguous), e_amb);
    endtask

    task automatic ack_result(input string tag);
        bus.result_ack = 1'b1;
        @(negedge clk);
        bus.result_ack = 1'b0;
        chk({tag, "_valid_dropped"}, 32'(bus.digit_valid), 0);
        chk({tag, "_idle"}, 32'(dut.state), 32'(IDLE));
    endtask

    initial begin
        int unstable;
        bus.network_done = 1'b0;
        bus.result_ack = 1'b0;
        load(40'h0);
        repeat (2) @(negedge clk);
        check_zero("reset");
        n_rst = 1'b1;
        @(negedge clk);

        load(40'h9876F54321);
        run_scan("peak", 5, 15, 0);
        chk("peak_overrun", 32'(bus.overrun), 0);
        unstable = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.digit_valid !== 1'b1 || bus.digit !== 4'd5 || bus.max_value !== 4'd15 || bus.ambiguous !== 1'b0) unstable++;
        end
        chk("hold_stable", unstable, 0);
        ack_result("peak");
        chk("keep_digit", 32'(bus.digit), 5);
        chk("keep_max", 32'(bus.max_value), 15);

        load(40'h00C0000C00);
        run_scan("tie", 2, 12, 1);
        ack_result("tie");

        load(40'h0);
        run_scan("zero", 0, 0, 1);
        ack_result("zero");

        load(40'hA000000009);
        run_scan("margin", 9, 10, 0);
        ack_result("margin");

        load(40'h1111117111);
        pulse_done();
        repeat (3) @(negedge clk);
        pulse_done();
        chk("mid_overrun", 32'(bus.overrun), 1);
        chk("mid_busy", 32'(bus.busy), 1);
        repeat (8) @(negedge clk);
        chk("ovr1_valid", 32'(bus.digit_valid), 1);
        chk("ovr1_digit", 32'(bus.digit), 3);
        chk("ovr1_max", 32'(bus.max_value), 7);
        load(40'h0E000000D0);
        run_scan("ovr2", 8, 14, 0);
        chk("ovr2_sticky", 32'(bus.overrun), 1);
        unstable = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.sig_rd_en !== 1'b0 || bus.digit_valid !== 1'b1) unstable++;
        end
        chk("no_third_scan", unstable, 0);
        ack_result("ovr2");

        load(40'h33333B3333);
        pulse_done();
        repeat (4) @(negedge clk);
        n_rst = 1'b0;
        #1;
        check_zero("async_rst");
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        run_scan("post_rst", 4, 11, 0);
        ack_result("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/digit_detector.md
# digit_detector

Output stage of the digit recognizer, downstream of the network controller. On a `network_done` pulse it scans the ten layer-2 sigmoid outputs from the sigmoid register file and selects the largest (argmax). It then presents the winning digit, its activation and an ambiguity flag to the SPI output side, holding them under a valid/ack handshake.

## Interface
- `NUM_CLASSES`, 10: number of output neurons scanned.
- `BASE_ADDR`, 8: sigmoid register address of class 0.
- `ADDR_W`, 5: sigmoid address width.
- `DATA_W`, 4: sigmoid value width (unsigned).
- `MARGIN`, 1: minimum best-minus-second gap for an unambiguous result.

Ports:
- `clk`  in  1  clock, rising edge.
- `n_rst`  in  1  reset, asynchronous, active-low.
- `network_done`  in  1  single-cycle pulse: layer-2 outputs are written and stable.
- `sig_rd_en`  out  1  sigmoid register file read strobe.
- `sig_rd_addr`  out  ADDR_W  sigmoid read address.
- `sig_rd_data`  in  DATA_W  read data, valid the cycle after `sig_rd_en`.
- `busy`  out  1  scan in progress.
- `digit`  out  4  winning class index, 0..9.
- `max_value`  out  DATA_W  winning activation.
- `ambiguous`  out  1  (best − second) < MARGIN.
- `digit_valid`  out  1  result available; held until acknowledged.
- `result_ack`  in  1  consumer has taken the result.
- `overrun`  out  1  sticky: a new `network_done` arrived before the previous result was acked.

## Operation
- States: IDLE, SCAN, DRAIN, FINISH, HOLD.
- **IDLE:** when `network_done` is 1, go to SCAN. Clear the index counter, `best` = 0, `second` = 0, `best_idx` = 0.
- **SCAN:** assert `sig_rd_en` with `sig_rd_addr` = BASE_ADDR + idx, and increment idx each cycle.
  - After idx = NUM_CLASSES−1 is issued, go to DRAIN.
- **Compare pipeline:** each returned sample v with index j is compared one cycle after its issue.
  - If v > best: second ← best, best ← v, best_idx ← j.
  - Else if v > second: second ← v.
  - Comparisons are strict, so on a tie the lower index wins and the tied value lands in `second`.
- **DRAIN:** consume the last sample, then go to FINISH.
- **FINISH:** register `digit` ← best_idx, `max_value` ← best, `ambiguous` ← ((best − second) < MARGIN), and `digit_valid` ← 1. Go to HOLD.
- **HOLD:**
  - `result_ack` = 1: `digit_valid` ← 0 and go to IDLE.
  - `network_done` = 1 (with or without ack): set `overrun`, drop `digit_valid`, and start a new SCAN directly.
- `network_done` during SCAN, DRAIN or FINISH: ignored, and `overrun` is set.
- `digit`, `max_value` and `ambiguous` keep their last values after ack until the next FINISH.
- The subtraction is unsigned DATA_W+1 wide; best ≥ second always holds.
- All-zero outputs give `digit` = 0, `max_value` = 0, `ambiguous` = 1 (with MARGIN ≥ 1).
- `busy` is 1 in SCAN, DRAIN and FINISH.

## Timing
- **Reset:** every output is 0; state IDLE.
- `network_done` is sampled at edge E0.
- `sig_rd_en` is high for cycles E1..E10, with addresses 8..17 (registered outputs).
- Data returns in cycles E2..E11.
- `digit_valid` rises at E12 (12-cycle latency) and stays high while `result_ack` is 0.
- `result_ack` sampled at edge Ek drops `digit_valid` at Ek; `network_done` may be accepted again from Ek+1.
- `sig_rd_addr` is 0 whenever `sig_rd_en` is 0.
- An asynchronous reset mid-scan aborts the scan and clears all outputs, including `overrun`.

## Structure
- Package `digit_pkg`: state enum `detState_t`, constants NUM_CLASSES, BASE_ADDR, DATA_W.
- The index counter is an instance of the existing `flex_counter` (NUM_CNT_BITS = 4, rollover NUM_CLASSES−1), cleared in IDLE.
- Compare/track logic stays inline; no other sub-modules.

## Test plan
- Outputs 0..9 = {1,2,3,4,5,15,6,7,8,9} → `digit` = 5, `max_value` = 15, `ambiguous` = 0, `digit_valid` exactly 12 cycles after `network_done`.
- Tie: class 2 = 12 and class 7 = 12, others 0 → `digit` = 2, `ambiguous` = 1.
- All zeros → `digit` = 0, `max_value` = 0, `ambiguous` = 1; check the address sequence is 8..17 with `sig_rd_en` high exactly 10 cycles.
- Hold `result_ack` low for 20 cycles → `digit_valid` and data stay stable; ack pulse → `digit_valid` 0 on the next edge, state IDLE.
- `network_done` mid-scan and again in HOLD → `overrun` = 1 (sticky), second result reflects the new data, and no third scan starts.
- Assert `n_rst` at cycle E5 → all outputs 0 immediately; a subsequent `network_done` produces a correct result.
